// File: rtl/dot_position_buffer_if.sv
// Processor-side write/commit port of the dot position buffer.
// The processor drives master; the buffer answers ready on slave.
interface dot_position_buffer_if #(
  parameter int INDEX_WIDTH = 3,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9
);
  logic                   wEn;
  logic [INDEX_WIDTH-1:0] wIndex;
  logic [X_WIDTH-1:0]     wX;
  logic [Y_WIDTH-1:0]     wY;
  logic                   wValid;
  logic                   commit;
  logic                   ready;

  modport master (output wEn, wIndex, wX, wY, wValid, commit, input ready);
  modport slave  (input wEn, wIndex, wX, wY, wValid, commit, output ready);
endinterface

// File: rtl/dot_position_buffer.sv
// Double-buffered dot table: the processor fills a back bank while the display
// hit-tests a stable front bank; banks swap on a frame boundary after commit.
module dot_position_buffer #(
  parameter int NUM_DOTS    = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  dot_position_buffer_if.slave   wr,
  input  logic                   screenEnd,
  input  logic [X_WIDTH-1:0]     pixX,
  input  logic [Y_WIDTH-1:0]     pixY,
  output logic                   isDot,
  output logic                   frameSwapped,
  output logic [COUNT_WIDTH-1:0] frameCount
);

  typedef enum logic [1:0] {FILL, PENDING, SWAP} state_t;

  state_t                 state_reg, state_next;
  logic                   front_reg;
  logic                   se_prev_reg;
  logic                   is_dot_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   se_rise;
  logic                   write_en;
  logic [NUM_DOTS-1:0]    hit_vec;

  assign se_rise  = screenEnd & ~se_prev_reg;
  assign write_en = (state_reg == FILL) && wr.wEn;

  always_comb begin
    state_next = state_reg;
    wr.ready   = 1'b0;
    case (state_reg)
      FILL: begin
        wr.ready = 1'b1;
        // A rise coinciding with commit is deliberately not consumed here.
        if (wr.commit) state_next = PENDING;
      end
      PENDING: if (se_rise) state_next = SWAP;
      SWAP:    state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= FILL;
      front_reg   <= 1'b0;
      se_prev_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      se_prev_reg <= screenEnd;
      if (state_reg == SWAP) front_reg <= ~front_reg;
      // Count on entry to SWAP so the new value is visible with the pulse.
      if (state_reg == PENDING && se_rise) count_reg <= count_reg + 1'b1;
    end
  end

  // Each entry keeps both banks locally; bit/slot [front_reg] is the display copy.
  // Out-of-range indices match no entry, so such writes fall away naturally.
  generate
    for (genvar gi = 0; gi < NUM_DOTS; gi++) begin : g_entry
      logic [1:0]              valid_reg;
      logic [1:0][X_WIDTH-1:0] x_reg;
      logic [1:0][Y_WIDTH-1:0] y_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= '0;
          x_reg     <= '0;
          y_reg     <= '0;
        end else if (state_reg == SWAP) begin
          // Old back becomes front; copy it so both banks hold the commit.
          valid_reg[front_reg] <= valid_reg[~front_reg];
          x_reg[front_reg]     <= x_reg[~front_reg];
          y_reg[front_reg]     <= y_reg[~front_reg];
        end else if (write_en && wr.wIndex == INDEX_WIDTH'(gi)) begin
          valid_reg[~front_reg] <= wr.wValid;
          x_reg[~front_reg]     <= wr.wX;
          y_reg[~front_reg]     <= wr.wY;
        end
      end

      assign hit_vec[gi] = valid_reg[front_reg] &&
                           (x_reg[front_reg] == pixX) &&
                           (y_reg[front_reg] == pixY);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) is_dot_reg <= 1'b0;
    else       is_dot_reg <= |hit_vec;
  end

  assign isDot        = is_dot_reg;
  assign frameSwapped = (state_reg == SWAP);
  assign frameCount   = count_reg;

endmodule
